pkt_rd_ctrl: RTL and testbench
==============================

// Module: pkt_rd_ctrl
// PURPOSE
//  Avalon-MM burst read master; read-back counterpart of the capture write path.
//  Starting at a record address in memory, it fetches one packet record and pushes the payload words into a downstream FIFO.
//  Record layout: header {seconds, nanoseconds, len, len}, then ceil(len/4) payload words.
//  Used for host read-out and replay of captured packets.
// PARAMETERS
//  MAX_BURST      16    max words per Avalon read burst (power of 2, <=64)
//  FIFO_DEPTH     512   depth of downstream FIFO in words (matches usedw width)
//  MAX_PKT_BYTES  2048  largest legal len; larger is a format error
// PORTS
//  clk            in   1   clock
//  reset          in   1   asynchronous, active-low reset
//  rd_ctrl        in   1   start pulse; sampled only in IDLE
//  read_address   in   32  byte address of record header (4-byte aligned), sampled with rd_ctrl
//  rd_ctrl_rdy    out  1   1-cycle pulse: record finished (ok or error)
//  rd_err         out  1   1-cycle pulse coincident with rd_ctrl_rdy on header error
//  pkt_seconds    out  32  header word 0, valid from CHECK until next start
//  pkt_nanosec    out  32  header word 1
//  pkt_len        out  32  header word 2 (bytes)
//  next_address   out  32  read_address + 16 + 4*ceil(len/4); valid with rd_ctrl_rdy
//  fifo_in        out  32  payload word to FIFO
//  wr_to_fifo     out  1   FIFO write strobe
//  usedw          in   9   FIFO fill level
//  address        out  32  Avalon byte address
//  read           out  1   Avalon read request
//  burstcount     out  16  Avalon burst length in words
//  readdata       in   32  Avalon read data
//  readdatavalid  in   1   Avalon read data valid
//  waitrequest    in   1   Avalon stall
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE.
//   Async assertion aborts any transfer at once; read drops the same instant.
//   Beats still in flight after release are ignored because the FSM is in IDLE.
//  FSM: IDLE -> HDR_REQ -> HDR_WAIT -> CHECK -> {DATA_REQ <-> DATA_WAIT} -> DONE -> IDLE.
//   Any header error leads CHECK -> ERR -> IDLE.
//  IDLE: on rd_ctrl=1, latch read_address and go to HDR_REQ the next cycle. rd_ctrl is ignored in every other state.
//  HDR_REQ: read=1, address=base, burstcount=4.
//   Hold all three stable while waitrequest=1.
//   Command is accepted on the cycle read=1 && waitrequest=0; go to HDR_WAIT.
//  HDR_WAIT: count readdatavalid beats 0..3 into seconds, nanosec, len, len2. After beat 3, go to CHECK.
//  CHECK (1 cycle), error cases:
//   - len != len2
//   - len == 0
//   - len > MAX_PKT_BYTES
//   On error go to ERR. Otherwise words_left = (len+3)>>2 (16 bit) and addr = base+16.
//  DATA_REQ:
//   - bc = min(MAX_BURST, words_left).
//   - Assert read only when FIFO_DEPTH-1-usedw >= bc+2. The +2 covers the registered push and usedw lag.
//   - Otherwise read=0 and keep waiting. Once read is asserted, it stays asserted until accepted.
//   - On accept, go to DATA_WAIT.
//  DATA_WAIT:
//   - Each readdatavalid: fifo_in<=readdata, wr_to_fifo<=1 on the next cycle (1-cycle push latency).
//   - Decrement the beat counter.
//   - After the last beat: addr += 4*bc, words_left -= bc.
//   - Then go to DATA_REQ if words_left>0, else DONE.
//   - Exactly one outstanding burst at a time; no pipelined commands.
//  DONE: rd_ctrl_rdy=1 for 1 cycle, next_address valid, then IDLE.
//  ERR: rd_ctrl_rdy=1 and rd_err=1 for 1 cycle. No payload words are pushed. next_address = base+16.
//  Last payload word is pushed unmasked; the consumer trims to pkt_len.
//  readdatavalid outside HDR_WAIT/DATA_WAIT is ignored.
//  Address arithmetic is 32-bit modulo 2^32; wrap is legal and not flagged.
//  A new rd_ctrl in the DONE or ERR cycle is ignored; it is accepted from IDLE only.
// TESTING
//  T1: hdr {5, 100, 64, 64} at 0x1000, zero-wait slave, FIFO empty.
//   -> 1 header burst (bc=4), 1 data burst (bc=16 @0x1010).
//   -> 16 FIFO pushes in order, rdy pulse, next_address=0x1050.
//  T2: len=70 -> 18 words.
//   -> Bursts bc=16 @base+16, then bc=2 @base+80.
//   -> next_address=base+88, pkt_len=70.
//  T3: waitrequest high 3 cycles on each command.
//   -> address/burstcount/read held stable.
//   -> Exactly one command per burst; data unchanged vs T1.
//  T4: len=64, len2=60.
//   -> No data read, no FIFO push, rdy+rd_err same cycle.
//   -> Also len=0 and len=4096 give an error.
//  T5: usedw=500 with len=64.
//   -> No data read issued. Drop usedw to 400 -> burst issued; no FIFO overflow.
//  T6: assert reset mid DATA_WAIT after 5 beats.
//   -> read=0 and wr_to_fifo=0 immediately. Late beats produce no pushes.
//   -> Fresh rd_ctrl completes normally.

Source files
------------

// File: rtl/pkt_rd_ctrl.sv
// pkt_rd_ctrl: Avalon-MM burst read master that fetches one captured packet record
// (4-word header followed by ceil(len/4) payload words) and pushes the payload into a
// downstream FIFO. Only one read burst is outstanding at a time.
`timescale 1ns/1ps

module pkt_rd_ctrl #(
    parameter int unsigned MAX_BURST     = 16,
    parameter int unsigned FIFO_DEPTH    = 512,
    parameter int unsigned MAX_PKT_BYTES = 2048
) (
    input  logic                          clk,
    input  logic                          reset,
    // Control interface
    input  logic                          rd_ctrl,
    input  logic [31:0]                   read_address,
    output logic                          rd_ctrl_rdy,
    output logic                          rd_err,
    output logic [31:0]                   pkt_seconds,
    output logic [31:0]                   pkt_nanosec,
    output logic [31:0]                   pkt_len,
    output logic [31:0]                   next_address,
    // Downstream FIFO
    output logic [31:0]                   fifo_in,
    output logic                          wr_to_fifo,
    input  logic [$clog2(FIFO_DEPTH)-1:0] usedw,
    // Avalon-MM read master
    output logic [31:0]                   address,
    output logic                          read,
    output logic [15:0]                   burstcount,
    input  logic [31:0]                   readdata,
    input  logic                          readdatavalid,
    input  logic                          waitrequest
);

    typedef enum logic [2:0] {
        StIdle,
        StHdrReq,
        StHdrWait,
        StCheck,
        StDataReq,
        StDataWait,
        StDone,
        StErr
    } state_e;

    state_e      state;
    logic [31:0] base_addr;   // record header address latched at start
    logic [31:0] len2;        // second copy of the length word
    logic [31:0] data_addr;   // byte address of the next payload burst
    logic [15:0] words_left;  // payload words still to be requested
    logic [15:0] beats_left;  // beats outstanding in the current data burst
    logic [1:0]  hdr_beat;    // header word index being received

    logic [15:0] burst_words;
    logic [31:0] fifo_space;
    logic        room_ok;
    logic        hdr_err;
    logic [31:0] burst_bytes;
    logic [15:0] words_after;

    // Burst sizing, FIFO headroom and header validity
    always_comb begin
        burst_words = (words_left > 16'(MAX_BURST)) ? 16'(MAX_BURST) : words_left;
        fifo_space  = 32'(FIFO_DEPTH) - 32'd1 - 32'(usedw);
        // Two spare entries cover the registered push and the usedw update lag.
        room_ok     = fifo_space >= (32'(burst_words) + 32'd2);
        hdr_err     = (pkt_len != len2) || (pkt_len == 32'd0) ||
                      (pkt_len > 32'(MAX_PKT_BYTES));
        burst_bytes = {14'd0, burstcount, 2'b00};
        words_after = words_left - burstcount;
    end

    // Control FSM with registered Avalon, FIFO and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= StIdle;
            base_addr    <= 32'd0;
            len2         <= 32'd0;
            data_addr    <= 32'd0;
            words_left   <= 16'd0;
            beats_left   <= 16'd0;
            hdr_beat     <= 2'd0;
            rd_ctrl_rdy  <= 1'b0;
            rd_err       <= 1'b0;
            pkt_seconds  <= 32'd0;
            pkt_nanosec  <= 32'd0;
            pkt_len      <= 32'd0;
            next_address <= 32'd0;
            fifo_in      <= 32'd0;
            wr_to_fifo   <= 1'b0;
            address      <= 32'd0;
            read         <= 1'b0;
            burstcount   <= 16'd0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            wr_to_fifo  <= 1'b0;
            rd_ctrl_rdy <= 1'b0;
            rd_err      <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (rd_ctrl) begin
                        base_addr  <= read_address;
                        address    <= read_address;
                        burstcount <= 16'd4;
                        read       <= 1'b1;
                        state      <= StHdrReq;
                    end
                end

                StHdrReq: begin
                    // read/address/burstcount stay put until the slave takes the command.
                    if (!waitrequest) begin
                        read     <= 1'b0;
                        hdr_beat <= 2'd0;
                        state    <= StHdrWait;
                    end
                end

                StHdrWait: begin
                    if (readdatavalid) begin
                        unique case (hdr_beat)
                            2'd0: pkt_seconds <= readdata;
                            2'd1: pkt_nanosec <= readdata;
                            2'd2: pkt_len     <= readdata;
                            2'd3: len2        <= readdata;
                        endcase
                        hdr_beat <= hdr_beat + 2'd1;
                        if (hdr_beat == 2'd3) begin
                            state <= StCheck;
                        end
                    end
                end

                StCheck: begin
                    if (hdr_err) begin
                        next_address <= base_addr + 32'd16;
                        rd_ctrl_rdy  <= 1'b1;
                        rd_err       <= 1'b1;
                        state        <= StErr;
                    end else begin
                        words_left <= 16'((pkt_len + 32'd3) >> 2);
                        data_addr  <= base_addr + 32'd16;
                        state      <= StDataReq;
                    end
                end

                StDataReq: begin
                    if (read) begin
                        if (!waitrequest) begin
                            read       <= 1'b0;
                            beats_left <= burstcount;
                            state      <= StDataWait;
                        end
                    end else if (room_ok) begin
                        // Once raised, read is held until accepted regardless of usedw.
                        read       <= 1'b1;
                        address    <= data_addr;
                        burstcount <= burst_words;
                    end
                end

                StDataWait: begin
                    if (readdatavalid) begin
                        fifo_in    <= readdata;
                        wr_to_fifo <= 1'b1;
                        beats_left <= beats_left - 16'd1;
                        if (beats_left == 16'd1) begin
                            data_addr  <= data_addr + burst_bytes;
                            words_left <= words_after;
                            if (words_after == 16'd0) begin
                                next_address <= data_addr + burst_bytes;
                                rd_ctrl_rdy  <= 1'b1;
                                state        <= StDone;
                            end else begin
                                state <= StDataReq;
                            end
                        end
                    end
                end

                StDone: begin
                    state <= StIdle;
                end

                StErr: begin
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_rd_ctrl.sv
// tb_pkt_rd_ctrl: scoreboard bench for pkt_rd_ctrl. A memory-backed Avalon slave serves
// bursts; a reference model derives expected commands, FIFO pushes and completion status
// from each record's header, and monitors compare DUT activity against those queues.
`timescale 1ns/1ps

module tb_pkt_rd_ctrl;

    localparam int unsigned FifoDepth = 512;
    localparam int unsigned MaxBurst  = 16;
    localparam int unsigned MaxBytes  = 2048;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_ctrl;
    logic [31:0] read_address;
    logic        rd_ctrl_rdy;
    logic        rd_err;
    logic [31:0] pkt_seconds;
    logic [31:0] pkt_nanosec;
    logic [31:0] pkt_len;
    logic [31:0] next_address;
    logic [31:0] fifo_in;
    logic        wr_to_fifo;
    logic [8:0]  usedw;
    logic [31:0] address;
    logic        read;
    logic [15:0] burstcount;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;

    pkt_rd_ctrl dut (
        .clk           (clk),
        .reset         (rst_n),
        .rd_ctrl       (rd_ctrl),
        .read_address  (read_address),
        .rd_ctrl_rdy   (rd_ctrl_rdy),
        .rd_err        (rd_err),
        .pkt_seconds   (pkt_seconds),
        .pkt_nanosec   (pkt_nanosec),
        .pkt_len       (pkt_len),
        .next_address  (next_address),
        .fifo_in       (fifo_in),
        .wr_to_fifo    (wr_to_fifo),
        .usedw         (usedw),
        .address       (address),
        .read          (read),
        .burstcount    (burstcount),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] bc;
        bit          is_data;
    } cmd_t;

    typedef struct {
        bit          err;
        logic [31:0] next_addr;
        logic [31:0] sec;
        logic [31:0] ns;
        logic [31:0] len;
    } done_t;

    int checks   = 0;
    int failures = 0;
    int push_cnt = 0;
    int rdy_cnt  = 0;
    int cmd_cnt  = 0;

    bit zero_wait  = 1'b1;
    int stall_n    = 0;
    int late_beats = 0;

    cmd_t        exp_cmd[$];
    logic [31:0] exp_push[$];
    done_t       exp_done[$];
    logic [31:0] mem[logic [31:0]];

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference model: lay out a record in memory and queue everything the DUT should do.
    task automatic expect_record(input logic [31:0] base, input logic [31:0] sec,
                                 input logic [31:0] ns, input logic [31:0] len,
                                 input logic [31:0] len2);
        cmd_t        c;
        done_t       d;
        bit          err;
        int unsigned words;
        int unsigned rem;
        int unsigned n;
        logic [31:0] a;
        logic [31:0] w;
        mem[base]          = sec;
        mem[base + 32'd4]  = ns;
        mem[base + 32'd8]  = len;
        mem[base + 32'd12] = len2;
        c.addr = base; c.bc = 16'd4; c.is_data = 1'b0;
        exp_cmd.push_back(c);
        err = (len != len2) || (len == 0) || (len > MaxBytes);
        d.sec = sec; d.ns = ns; d.len = len; d.err = err;
        if (err) begin
            d.next_addr = base + 32'd16;
        end else begin
            words = (len + 3) / 4;
            for (int i = 0; i < int'(words); i++) begin
                w = $urandom;
                mem[base + 32'd16 + 32'(4 * i)] = w;
                exp_push.push_back(w);
            end
            a   = base + 32'd16;
            rem = words;
            while (rem > 0) begin
                n = (rem > MaxBurst) ? MaxBurst : rem;
                c.addr = a; c.bc = 16'(n); c.is_data = 1'b1;
                exp_cmd.push_back(c);
                a   = a + 32'(4 * n);
                rem = rem - n;
            end
            d.next_addr = a;
        end
        exp_done.push_back(d);
    endtask

    task automatic start_pkt(input logic [31:0] base);
        @(negedge clk);
        rd_ctrl      = 1'b1;
        read_address = base;
        @(negedge clk);
        rd_ctrl      = 1'b0;
        read_address = $urandom;
    endtask

    task automatic wait_done();
        int start;
        int n;
        start = rdy_cnt;
        n     = 0;
        while (rdy_cnt == start && n < 6000) begin
            @(posedge clk);
            n++;
        end
        if (rdy_cnt == start) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no rd_ctrl_rdy expected one within 6000 cycles");
        end
        check("push_queue_drained", 32'(exp_push.size()), 32'd0);
        check("cmd_queue_drained", 32'(exp_cmd.size()), 32'd0);
        exp_push.delete();
        exp_cmd.delete();
        exp_done.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic run_pkt(input logic [31:0] base, input logic [31:0] sec,
                           input logic [31:0] ns, input logic [31:0] len,
                           input logic [31:0] len2, input bit poke_busy);
        expect_record(base, sec, ns, len, len2);
        start_pkt(base);
        if (poke_busy) begin
            // A start while busy must be ignored.
            @(negedge clk);
            rd_ctrl      = 1'b1;
            read_address = 32'h5555_0000;
            @(negedge clk);
            rd_ctrl      = 1'b0;
        end
        wait_done();
    endtask

    // Avalon slave: serves beats from memory, checks commands and command hold.
    initial begin
        logic [31:0] pend[$];
        logic [31:0] a;
        logic [31:0] prev_addr;
        logic [15:0] prev_bc;
        bit          prev_hold;
        int          stall_cnt;
        cmd_t        c;
        prev_hold = 1'b0;
        stall_cnt = 0;
        prev_addr = 32'd0;
        prev_bc   = 16'd0;
        waitrequest   = 1'b0;
        readdatavalid = 1'b0;
        readdata      = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend.delete();
                readdatavalid = 1'b0;
                waitrequest   = 1'b0;
                prev_hold     = 1'b0;
                stall_cnt     = 0;
                continue;
            end
            readdatavalid = 1'b0;
            readdata      = $urandom;
            if (pend.size() > 0) begin
                if (zero_wait || $urandom_range(0, 3) != 0) begin
                    a             = pend.pop_front();
                    readdatavalid = 1'b1;
                    readdata      = rd_mem(a);
                end
            end else if (late_beats > 0) begin
                readdatavalid = 1'b1;
                late_beats--;
            end
            if (prev_hold) begin
                check("cmd_hold_read", 32'(read), 32'd1);
                check("cmd_hold_addr", address, prev_addr);
                check("cmd_hold_bc", 32'(burstcount), 32'(prev_bc));
            end
            if (read) begin
                if (stall_n > 0 && stall_cnt < stall_n) begin
                    waitrequest = 1'b1;
                    stall_cnt++;
                end else if (!zero_wait && $urandom_range(0, 2) == 0) begin
                    waitrequest = 1'b1;
                end else begin
                    waitrequest = 1'b0;
                    stall_cnt   = 0;
                    cmd_cnt++;
                    if (exp_cmd.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_cmd: got addr %h bc %0d expected none",
                                 address, burstcount);
                    end else begin
                        c = exp_cmd.pop_front();
                        check("cmd_addr", address, c.addr);
                        check("cmd_bc", 32'(burstcount), 32'(c.bc));
                        if (c.is_data) begin
                            check("cmd_fifo_room",
                                  32'((FifoDepth - 1 - 32'(usedw)) >= 32'(burstcount) + 2),
                                  32'd1);
                        end
                    end
                    for (int i = 0; i < int'(burstcount); i++) begin
                        pend.push_back(address + 32'(4 * i));
                    end
                end
                prev_hold = waitrequest;
                prev_addr = address;
                prev_bc   = burstcount;
            end else begin
                waitrequest = 1'b0;
                prev_hold   = 1'b0;
            end
        end
    end

    // Output monitor: FIFO pushes and completion pulses against the scoreboard.
    initial begin
        logic [31:0] w;
        done_t       d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wr_to_fifo) begin
                    push_cnt++;
                    if (exp_push.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_push: got %h expected none", fifo_in);
                    end else begin
                        w = exp_push.pop_front();
                        check("fifo_word", fifo_in, w);
                    end
                end
                if (rd_err && !rd_ctrl_rdy) begin
                    checks++;
                    failures++;
                    $display("FAIL err_without_rdy: got rd_err=1 rdy=0 expected rdy=1");
                end
                if (rd_ctrl_rdy) begin
                    rdy_cnt++;
                    if (exp_done.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rdy: got rdy expected none");
                    end else begin
                        d = exp_done.pop_front();
                        check("done_err", 32'(rd_err), 32'(d.err));
                        check("done_next_addr", next_address, d.next_addr);
                        check("done_seconds", pkt_seconds, d.sec);
                        check("done_nanosec", pkt_nanosec, d.ns);
                        check("done_len", pkt_len, d.len);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish expected finish before 900us");
        $fatal(1, "timeout");
    end

    initial begin
        int          c0;
        int          p0;
        int          r0;
        int          n;
        int          sel;
        logic [31:0] len;
        logic [31:0] len2;
        rst_n        = 1'b0;
        rd_ctrl      = 1'b0;
        read_address = 32'd0;
        usedw        = 9'd0;
        repeat (3) @(negedge clk);
        check("rst_read", 32'(read), 32'd0);
        check("rst_wr_to_fifo", 32'(wr_to_fifo), 32'd0);
        check("rst_rdy", 32'(rd_ctrl_rdy), 32'd0);
        check("rst_err", 32'(rd_err), 32'd0);
        check("rst_address", address, 32'd0);
        check("rst_burstcount", 32'(burstcount), 32'd0);
        check("rst_next_address", next_address, 32'd0);
        check("rst_pkt_len", pkt_len, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic record, zero-wait slave.
        zero_wait = 1'b1;
        run_pkt(32'h0000_1000, 32'd5, 32'd100, 32'd64, 32'd64, 1'b0);
        // Split bursts 16 + 2.
        run_pkt(32'h0000_2000, 32'd7, 32'd8, 32'd70, 32'd70, 1'b0);
        // Stalled commands must be held and issued once.
        stall_n = 3;
        run_pkt(32'h0000_1000, 32'd5, 32'd100, 32'd64, 32'd64, 1'b0);
        stall_n = 0;
        // Header errors and length boundaries.
        run_pkt(32'h0000_5000, 32'd1, 32'd2, 32'd64, 32'd60, 1'b0);
        run_pkt(32'h0000_5100, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0);
        run_pkt(32'h0000_5200, 32'd5, 32'd6, 32'd4096, 32'd4096, 1'b0);
        run_pkt(32'h0000_5300, 32'd7, 32'd8, 32'd2049, 32'd2049, 1'b0);
        run_pkt(32'h0000_6000, 32'd9, 32'd10, 32'd2048, 32'd2048, 1'b0);
        run_pkt(32'h0000_7000, 32'd11, 32'd12, 32'd1, 32'd1, 1'b1);
        // Address wrap past 2^32.
        run_pkt(32'hFFFF_FFE0, 32'd13, 32'd14, 32'd40, 32'd40, 1'b0);

        // FIFO headroom gating: 511-500 and 511-494 are short of 18, 511-493 is enough.
        usedw = 9'd500;
        expect_record(32'h0000_3000, 32'd21, 32'd22, 32'd64, 32'd64);
        c0 = cmd_cnt;
        start_pkt(32'h0000_3000);
        repeat (40) @(negedge clk);
        check("full_cmds_500", 32'(cmd_cnt - c0), 32'd1);
        check("full_read_low_500", 32'(read), 32'd0);
        usedw = 9'd494;
        repeat (10) @(negedge clk);
        check("full_cmds_494", 32'(cmd_cnt - c0), 32'd1);
        check("full_read_low_494", 32'(read), 32'd0);
        usedw = 9'd493;
        wait_done();
        usedw = 9'd0;

        // Randomized records with a jittery slave.
        zero_wait = 1'b0;
        for (int i = 0; i < 15; i++) begin
            sel   = $urandom_range(0, 99);
            usedw = 9'($urandom_range(0, 400));
            len   = 32'($urandom_range(1, MaxBytes));
            len2  = len;
            if (sel < 8) len2 = len + 32'd1;
            else if (sel < 11) begin len = 32'd0; len2 = 32'd0; end
            else if (sel < 14) begin len = 32'($urandom_range(MaxBytes + 1, 65535)); len2 = len; end
            run_pkt($urandom & 32'hFFFF_FFFC, $urandom, $urandom, len, len2, (i % 4) == 0);
        end
        usedw = 9'd0;

        // Asynchronous reset in the middle of a data burst.
        zero_wait = 1'b1;
        expect_record(32'h0000_4000, 32'd31, 32'd32, 32'd64, 32'd64);
        p0 = push_cnt;
        start_pkt(32'h0000_4000);
        n = 0;
        while (push_cnt - p0 < 5 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("abort_reached_5_pushes", 32'(push_cnt - p0 >= 5), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_read_low", 32'(read), 32'd0);
        check("abort_wr_low", 32'(wr_to_fifo), 32'd0);
        check("abort_rdy_low", 32'(rd_ctrl_rdy), 32'd0);
        exp_push.delete();
        exp_cmd.delete();
        exp_done.delete();
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        late_beats = 3;
        p0 = push_cnt;
        r0 = rdy_cnt;
        repeat (12) @(negedge clk);
        check("late_beats_no_push", 32'(push_cnt - p0), 32'd0);
        check("late_beats_no_rdy", 32'(rdy_cnt - r0), 32'd0);
        run_pkt(32'h0000_4000, 32'd41, 32'd42, 32'd64, 32'd64, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
